// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the register-slave FSM state type.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  localparam logic [2:0] HSIZE_8  = 3'b000;
  localparam logic [2:0] HSIZE_16 = 3'b001;
  localparam logic [2:0] HSIZE_32 = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } ahb_slv_state_t;

endpackage

// File: rtl/ahb_lite_wstrb.sv
// Byte-lane strobe and alignment check for one AHB-Lite address phase.
module ahb_lite_wstrb
  import ahb_lite_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_i,
  output logic [3:0] strb_o,
  output logic       misalign_o
);

  always_comb begin
    strb_o     = 4'b0000;
    misalign_o = 1'b0;
    case (hsize_i)
      HSIZE_8:  strb_o = 4'b0001 << addr_i;
      HSIZE_16: begin
        strb_o     = addr_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = addr_i[0];
      end
      HSIZE_32: begin
        strb_o     = 4'b1111;
        misalign_o = (addr_i != 2'b00);
      end
      default: strb_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahb_lite_reg_slave.sv
// AHB-Lite register bank: read-only ID at index 0, byte-laned writable registers
// above it, optional wait states and the two-cycle ERROR response.
module ahb_lite_reg_slave
  import ahb_lite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_2000,
  parameter int          ADDR_W      = 12,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA51C_0001
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ahb_hsel_i,
  input  logic [31:0]           ahb_haddr_i,
  input  logic                  ahb_hwrite_i,
  input  logic [2:0]            ahb_hsize_i,
  input  logic [1:0]            ahb_htrans_i,
  input  logic [31:0]           ahb_hwdata_i,
  input  logic                  ahb_hreadyin_i,
  output logic                  ahb_hready_o,
  output logic                  ahb_hresp_o,
  output logic [31:0]           ahb_hrdata_o,
  output logic [32*NUM_REGS-1:0] regs_o
);

  localparam int IDX_W = ADDR_W - 2;

  ahb_slv_state_t   state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             dvalid_q, dvalid_d;
  logic             wr_q, wr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       strb_q, strb_d;

  logic [3:0] strb_a;
  logic       misalign_a;
  logic       trans_act, accept, err_a, commit;

  ahb_lite_wstrb u_wstrb (
    .hsize_i    (ahb_hsize_i),
    .addr_i     (ahb_haddr_i[1:0]),
    .strb_o     (strb_a),
    .misalign_o (misalign_a)
  );

  // Handshake: an address phase is taken only while this slave drives HREADYOUT
  // high, i.e. the cycle that ends the previous data phase (or an idle bus).
  assign ahb_hready_o = (state_q == IDLE) || (state_q == ERR2);
  assign ahb_hresp_o  = ((state_q == ERR1) || (state_q == ERR2)) ? HRESP_ERROR : HRESP_OKAY;

  assign trans_act = (ahb_htrans_i == HTRANS_NSEQ) || (ahb_htrans_i == HTRANS_SEQ);
  assign accept    = ahb_hsel_i && ahb_hreadyin_i && trans_act && ahb_hready_o;
  assign err_a     = (ahb_haddr_i[31:ADDR_W] != BASE_ADDR[31:ADDR_W]) ||
                     ({{(32-IDX_W){1'b0}}, ahb_haddr_i[ADDR_W-1:2]} >= 32'(NUM_REGS)) ||
                     (ahb_hsize_i > HSIZE_32) || misalign_a;
  // An IDLE-state cycle with a pending data phase is its completing cycle.
  assign commit    = (state_q == IDLE) && dvalid_q && wr_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvalid_d = dvalid_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    strb_d   = strb_q;
    case (state_q)
      IDLE: dvalid_d = 1'b0;
      WAIT: begin
        if (cnt_q <= 4'd1) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ERR1: state_d = ERR2;
      ERR2: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      wr_d   = ahb_hwrite_i;
      idx_d  = ahb_haddr_i[ADDR_W-1:2];
      strb_d = strb_a;
      if (err_a) begin
        state_d  = ERR1;
        dvalid_d = 1'b0;
      end else begin
        dvalid_d = 1'b1;
        if (WAIT_STATES == 0) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      dvalid_q <= 1'b0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      strb_q   <= 4'b0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvalid_q <= dvalid_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      strb_q   <= strb_d;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    if (k == 0) begin : g_id
      assign regs_o[31:0] = ID_VALUE;
    end else begin : g_rw
      logic [31:0] r_q;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_q <= 32'd0;
        end else if (commit && (idx_q == IDX_W'(k))) begin
          for (int b = 0; b < 4; b++) begin
            if (strb_q[b]) r_q[8*b +: 8] <= ahb_hwdata_i[8*b +: 8];
          end
        end
      end
      assign regs_o[32*k +: 32] = r_q;
    end
  end

  always_comb begin
    ahb_hrdata_o = 32'd0;
    if (dvalid_q && !wr_q) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (idx_q == IDX_W'(k)) ahb_hrdata_o = regs_o[32*k +: 32];
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_reg_slave.sv
// Bench for ahb_lite_reg_slave: a zero-wait and a 3-wait instance checked
// against an array model of the register bank.
module tb_ahb_lite_reg_slave;
  import ahb_lite_pkg::*;

  localparam logic [31:0] ID = 32'hA51C_0001;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        hsel   [2];
  logic [31:0] haddr  [2];
  logic        hwrite [2];
  logic [2:0]  hsize  [2];
  logic [1:0]  htrans [2];
  logic [31:0] hwdata [2];
  wire         hready [2];
  wire         hresp  [2];
  wire  [31:0] hrdata [2];
  wire  [255:0] regs  [2];

  ahb_lite_reg_slave #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .resetn(resetn),
    .ahb_hsel_i(hsel[0]), .ahb_haddr_i(haddr[0]), .ahb_hwrite_i(hwrite[0]),
    .ahb_hsize_i(hsize[0]), .ahb_htrans_i(htrans[0]), .ahb_hwdata_i(hwdata[0]),
    .ahb_hreadyin_i(hready[0]), .ahb_hready_o(hready[0]), .ahb_hresp_o(hresp[0]),
    .ahb_hrdata_o(hrdata[0]), .regs_o(regs[0])
  );

  ahb_lite_reg_slave #(.WAIT_STATES(3)) u_dut3 (
    .clk(clk), .resetn(resetn),
    .ahb_hsel_i(hsel[1]), .ahb_haddr_i(haddr[1]), .ahb_hwrite_i(hwrite[1]),
    .ahb_hsize_i(hsize[1]), .ahb_htrans_i(htrans[1]), .ahb_hwdata_i(hwdata[1]),
    .ahb_hreadyin_i(hready[1]), .ahb_hready_o(hready[1]), .ahb_hresp_o(hresp[1]),
    .ahb_hrdata_o(hrdata[1]), .regs_o(regs[1])
  );

  int total = 0;
  int bad = 0;
  logic [31:0] mdl [2][8];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ws(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  function automatic logic [255:0] mdl_vec(input int d);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = mdl[d][k];
    return v;
  endfunction

  // Legal: inside the 4 KB window, index below 8, size up to a word, naturally aligned.
  function automatic bit exp_err(input logic [31:0] a, input logic [2:0] s);
    if (a[31:12] != 20'h80002) return 1'b1;
    if (a[11:2] >= 10'd8) return 1'b1;
    if (s > 3'd2) return 1'b1;
    if ((a % (32'd1 << s)) != 32'd0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) mdl[d][k] = 32'd0;
      mdl[d][0] = ID;
    end
  endtask

  task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] s,
                             input logic [31:0] wd);
    int idx, st, n;
    idx = int'(a[11:2]);
    st  = int'(a[1:0]);
    n   = 1 << s;
    if (idx != 0) begin
      for (int b = st; b < st + n; b++) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_idle(input int d);
    hsel[d] = 1'b0; haddr[d] = 32'd0; hwrite[d] = 1'b0;
    hsize[d] = HSIZE_32; htrans[d] = HTRANS_IDLE; hwdata[d] = 32'd0;
  endtask

  task automatic addr_phase(input int d, input bit wr, input logic [31:0] a, input logic [2:0] s);
    hsel[d] = 1'b1; haddr[d] = a; hwrite[d] = wr; hsize[d] = s; htrans[d] = HTRANS_NSEQ;
  endtask

  task automatic xfer_chk(input int d, input bit wr, input logic [31:0] a, input logic [2:0] s,
                          input logic [31:0] wd, input string tag);
    int w;
    bit e, first_rp;
    logic [31:0] exp_rd;
    e = exp_err(a, s);
    exp_rd = (e || wr) ? 32'd0 : mdl[d][int'(a[11:2])];
    w = 0;
    while (!hready[d] && w < 50) begin w++; step(); end
    addr_phase(d, wr, a, s);
    step();
    bus_idle(d);
    hwdata[d] = wd;
    first_rp = hresp[d];
    w = 0;
    while (!hready[d] && w < 50) begin w++; step(); end
    chk($sformatf("%s_wait", tag), 256'(w), 256'(e ? 1 : ws(d)));
    chk($sformatf("%s_resp0", tag), 256'(first_rp), 256'(e));
    chk($sformatf("%s_resp", tag), 256'(hresp[d]), 256'(e));
    chk($sformatf("%s_rdata", tag), 256'(hrdata[d]), 256'(exp_rd));
    step();
    hwdata[d] = 32'd0;
    if (!e && wr) model_write(d, a, s, wd);
    chk($sformatf("%s_regs", tag), regs[d], mdl_vec(d));
  endtask

  // Word write immediately followed by a word read whose address phase overlaps the write data phase.
  task automatic b2b(input int d, input logic [31:0] wa, input logic [31:0] wd,
                     input logic [31:0] ra, input string tag);
    int w;
    addr_phase(d, 1'b1, wa, HSIZE_32);
    step();
    hwdata[d] = wd;
    addr_phase(d, 1'b0, ra, HSIZE_32);
    w = 0;
    while (!hready[d] && w < 50) begin w++; step(); end
    chk($sformatf("%s_wwait", tag), 256'(w), 256'(ws(d)));
    step();
    bus_idle(d);
    model_write(d, wa, HSIZE_32, wd);
    w = 0;
    while (!hready[d] && w < 50) begin w++; step(); end
    chk($sformatf("%s_rwait", tag), 256'(w), 256'(ws(d)));
    chk($sformatf("%s_rdata", tag), 256'(hrdata[d]), 256'(mdl[d][int'(ra[11:2])]));
    chk($sformatf("%s_resp", tag), 256'(hresp[d]), 256'(0));
    step();
    chk($sformatf("%s_regs", tag), regs[d], mdl_vec(d));
  endtask

  initial begin
    int d;
    logic [31:0] a, wd;
    logic [2:0] s;
    bit wr;
    bus_idle(0);
    bus_idle(1);
    model_reset();
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    step();

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_hready%0d", i), 256'(hready[i]), 256'(1));
      chk($sformatf("rst_hresp%0d", i), 256'(hresp[i]), 256'(0));
      chk($sformatf("rst_hrdata%0d", i), 256'(hrdata[i]), 256'(0));
      chk($sformatf("rst_regs%0d", i), regs[i], {224'd0, ID});
    end

    for (int i = 0; i < 2; i++) begin
      xfer_chk(i, 1'b0, 32'h8000_2000, HSIZE_32, 32'd0, "id_rd");
      b2b(i, 32'h8000_2004, 32'hDEAD_BEEF, 32'h8000_2004, "b2b");
      chk("b2b_reg1", 256'(regs[i][63:32]), 256'(32'hDEAD_BEEF));
      xfer_chk(i, 1'b1, 32'h8000_2006, HSIZE_8, {4{8'h55}}, "byte_wr");
      chk("byte_reg1", 256'(regs[i][63:32]), 256'(32'hDE55_BEEF));
      xfer_chk(i, 1'b1, 32'h8000_2004, HSIZE_16, {2{16'h1234}}, "half_wr");
      chk("half_reg1", 256'(regs[i][63:32]), 256'(32'hDE55_1234));
      xfer_chk(i, 1'b0, 32'h8000_2020, HSIZE_32, 32'd0, "err_idx");
      xfer_chk(i, 1'b1, 32'h8000_2005, HSIZE_32, 32'hFFFF_FFFF, "err_align");
      xfer_chk(i, 1'b1, 32'h8000_2003, HSIZE_16, 32'hFFFF_FFFF, "err_half");
      xfer_chk(i, 1'b1, 32'h8000_2008, 3'b011, 32'hFFFF_FFFF, "err_size");
      xfer_chk(i, 1'b1, 32'h8000_3008, HSIZE_32, 32'hFFFF_FFFF, "err_win");
      xfer_chk(i, 1'b1, 32'h8000_2000, HSIZE_32, 32'h1111_1111, "wr_id");
      xfer_chk(i, 1'b1, 32'h8000_2008, HSIZE_32, 32'hCAFE_0001, "cafe_wr");
      xfer_chk(i, 1'b0, 32'h8000_2008, HSIZE_32, 32'd0, "cafe_rd");
    end

    for (int i = 0; i < 80; i++) begin
      d  = int'($urandom_range(0, 1));
      a  = 32'h8000_2000 + $urandom_range(0, 40);
      if ($urandom_range(0, 9) == 0) a = a ^ 32'h0000_1000;
      s  = 3'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      xfer_chk(d, wr, a, s, wd, $sformatf("rnd%0d", i));
    end

    addr_phase(1, 1'b1, 32'h8000_200C, HSIZE_32);
    step();
    bus_idle(1);
    hwdata[1] = 32'h1234_5678;
    chk("mid_hready_low", 256'(hready[1]), 256'(0));
    step();
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_hready", 256'(hready[1]), 256'(1));
    chk("mid_rst_hresp", 256'(hresp[1]), 256'(0));
    chk("mid_rst_hrdata", 256'(hrdata[1]), 256'(0));
    model_reset();
    #3 resetn = 1'b1;
    step();
    bus_idle(1);
    chk("mid_rst_reg3", 256'(regs[1][127:96]), 256'(0));
    chk("mid_rst_regs0", regs[0], mdl_vec(0));
    chk("mid_rst_regs1", regs[1], mdl_vec(1));
    xfer_chk(1, 1'b0, 32'h8000_200C, HSIZE_32, 32'd0, "rst_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_lite_reg_slave.md
Name: ahb_lite_reg_slave

Overview:
AHB-Lite subordinate (responder) exposing a bank of 32-bit control/status registers at a 4 KB window. It is the responder end of the AHB-Lite interface that the bench master drives, and the target for classifier configuration writes and readback. It supports configurable wait states, byte/halfword/word writes via byte lanes, and the two-cycle ERROR response for illegal accesses.

Parameters:
BASE_ADDR, 32'h8000_2000, window base; only HADDR[31:ADDR_W] is compared.
ADDR_W, 12, window size in address bits; 4 KB by default.
NUM_REGS, 8, number of registers; legal range 1..2^(ADDR_W-2).
WAIT_STATES, 0, number of HREADY-low cycles inserted per OKAY data phase; legal range 0..15.
ID_VALUE, 32'hA51C_0001, read-only contents of register 0.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
ahb_hsel_i  in  1  slave select
ahb_haddr_i  in  32  address
ahb_hwrite_i  in  1  1 = write
ahb_hsize_i  in  3  transfer size
ahb_htrans_i  in  2  transfer type
ahb_hwdata_i  in  32  write data, valid in the data phase
ahb_hreadyin_i  in  1  bus HREADY, previous transfer complete
ahb_hready_o  out  1  HREADYOUT
ahb_hresp_o  out  1  0 = OKAY, 1 = ERROR
ahb_hrdata_o  out  32  read data
regs_o  out  32*NUM_REGS  flattened register contents, reg k at [32k+31:32k]

Behaviour:
- Reset (asynchronous, active-low):
  - FSM returns to IDLE.
  - ahb_hready_o=1, ahb_hresp_o=0, ahb_hrdata_o=0.
  - Registers 1..NUM_REGS-1 clear to 0.
  - Reset mid-transfer abandons the transfer; no register write occurs.
- Address phase accept:
  - Accepted when hsel & hreadyin & htrans[1] (NSEQ or SEQ) at a rising edge.
  - IDLE or BUSY transfers are not accepted; they get a zero-wait OKAY.
  - On accept, latch write, size, word index = haddr[ADDR_W-1:2], byte offset = haddr[1:0], and the error flag.
- Error conditions, any of:
  - haddr[31:ADDR_W] != BASE_ADDR[31:ADDR_W].
  - Word index >= NUM_REGS.
  - hsize > 3'b010.
  - Halfword with addr[0]=1.
  - Word with addr[1:0] != 0.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE, accept, no error, WAIT_STATES=0: stay IDLE, next cycle is a zero-wait data phase (hready_o=1).
  - IDLE, accept, no error, WAIT_STATES>0: go to WAIT, load counter = WAIT_STATES, hready_o=0.
  - WAIT: decrement each cycle. When the counter reaches 1, hready_o=1 for the final data-phase cycle, then return to IDLE (or accept a pipelined next transfer).
  - IDLE or WAIT end, accept with error: go to ERR1.
  - ERR1: hready_o=0, hresp_o=1, then go to ERR2.
  - ERR2: hready_o=1, hresp_o=1. A new address phase may be accepted in this cycle.
- Pipelining:
  - A new address phase is sampled only in the cycle where hready_o=1 ends the previous data phase.
  - Back-to-back NSEQs are supported.
- Write:
  - Committed at the edge where the data phase completes (hready_o=1, OKAY) using ahb_hwdata_i.
  - Byte strobes: byte → lane addr[1:0]; halfword → lanes {addr[1],0} and +1; word → all 4 lanes.
  - Writes to register 0 are ignored with an OKAY response.
  - ERROR transfers never write.
- Read:
  - ahb_hrdata_o is combinational from the latched index during a read data phase.
  - It is 0 otherwise, including during ERROR.
  - Register 0 returns ID_VALUE.
  - A read immediately following a write to the same register returns the new value.
- regs_o is a continuous view of the register array; register 0 slot = ID_VALUE.

Decomposition:
- Package ahb_lite_pkg holds:
  - HTRANS_IDLE/BUSY/NSEQ/SEQ constants.
  - HSIZE_8/16/32 constants.
  - HRESP_OKAY/ERROR constants.
  - ahb_slv_state_t enum {IDLE, WAIT, ERR1, ERR2}.
- Sub-module ahb_lite_wstrb is natural: combinational (hsize, addr[1:0]) → 4-bit byte strobe plus misalignment flag.

Test Plan:
- Reset, then read 0x8000_2000 → hrdata=0xA51C_0001, OKAY, zero wait; regs_o all 0 except slot 0.
- Word write 0xDEAD_BEEF to 0x8000_2004, then back-to-back read of 0x8000_2004 → 0xDEAD_BEEF; regs_o[63:32]=0xDEAD_BEEF.
- Byte write 0x55 to 0x8000_2006 over 0xDEAD_BEEF → reg1=0xDE55_BEEF; halfword write 0x1234 to 0x8000_2004 → reg1=0xDE55_1234.
- Read 0x8000_2020 (index 8) and word access to 0x8000_2005 → ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1); registers unchanged.
- WAIT_STATES=3 build, write 0xCAFE_0001 to 0x8000_2008 → exactly 3 hready-low cycles then the commit; a following read also takes 3 wait cycles and returns 0xCAFE_0001.
- Assert resetn low during a WAIT-state write to 0x8000_200C → hready=1 immediately; reg3 stays 0 after reset release.
